// File: rtl/sw_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
// The counter width is sized so the largest legal count always fits.
package sw_pkg;

    localparam int SW_WIDTH          = 7;
    localparam int DB_CYCLES_DEFAULT = 1000000;

    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sw_db_bit.sv
// One debounced switch bit: a two-flop synchronizer, a stability counter,
// the accepted level, and registered rise/fall pulses.
module sw_db_bit
    import sw_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
)
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o,
    output logic accept_o
);

    localparam int              CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          db;
    logic [CW-1:0] cnt;
    logic          accept;

    // A new level is taken only once it has differed on DB_CYCLES consecutive edges.
    assign accept   = (s2 != db) && (cnt == CNT_LAST);
    assign accept_o = accept;
    assign sw_o     = db;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            db     <= 1'b0;
            cnt    <= '0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            s1     <= sw_i;
            s2     <= s1;
            rise_o <= accept & s2;
            fall_o <= accept & ~s2;
            if (s2 == db) begin
                cnt <= '0;
            end else if (accept) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Debounces a bank of slide switches, mirrors them onto LEDs and keeps a
// running modulo-256 count of every accepted level change.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int WIDTH     = SW_WIDTH,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] led_o,
    output logic [7:0]       chg_cnt_o
);

    logic [WIDTH-1:0] accept;
    logic [7:0]       accept_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_db_bit #(
            .DB_CYCLES (DB_CYCLES)
        ) u_bit (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .sw_i     (sw_i[i]),
            .sw_o     (sw_o[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i]),
            .accept_o (accept[i])
        );
    end

    assign led_o = sw_o;

    // Counted on the acceptance edge itself so the count moves with sw_o and the pulses.
    always_comb begin
        accept_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept_cnt = accept_cnt + 8'(accept[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chg_cnt_o <= '0;
        end else begin
            chg_cnt_o <= chg_cnt_o + accept_cnt;
        end
    end

endmodule
